// File: rtl/dpot_spi_rx.sv
// dpot_spi_rx: SPI receiver standing in for the Pmod DPOT serial input.
// Oversamples nCS/SCLK/MOSI with clk_i and shifts in 8-bit frames MSB-first
// on SCLK rising edges. The wiper code is committed only when nCS returns
// high after exactly 8 bits. Any other bit count is reported as a frame error.
module dpot_spi_rx #(
   parameter logic [7:0] RESET_VALUE = 8'h80
) (
   input  logic       clk_i,
   input  logic       rst,
   input  logic       nCS,
   input  logic       SCLK,
   input  logic       MOSI,
   output logic [7:0] value,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_ARM,
      ST_IDLE,
      ST_RECV
   } state_t;

   state_t      r_state;
   state_t      w_next_state;

   logic        r_ncs_s1, r_ncs_s2, r_ncs_h;
   logic        r_sclk_s1, r_sclk_s2, r_sclk_h;
   logic        r_mosi_s1, r_mosi_s2;
   logic [1:0]  r_prime;
   logic [7:0]  r_shift;
   logic [3:0]  r_count;

   logic        w_ncs_fall, w_ncs_rise, w_sclk_rise;
   logic        w_start, w_shift, w_commit, w_discard;

   // Edge detection compares the second synchronizer stage with its history flop.
   // MOSI is taken from the same stage depth, so it stays aligned with SCLK.
   assign w_ncs_fall  =  r_ncs_h  & ~r_ncs_s2;
   assign w_ncs_rise  = ~r_ncs_h  &  r_ncs_s2;
   assign w_sclk_rise = ~r_sclk_h &  r_sclk_s2;

   assign busy = (r_state == ST_RECV);

   // Two-flop synchronizers plus history flops. nCS idles high and SCLK/MOSI idle low.
   // NOTE: sequential state is written only with non-blocking assignments,
   // so every flop samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_ncs_s1  <= 1'b1;
         r_ncs_s2  <= 1'b1;
         r_ncs_h   <= 1'b1;
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_h  <= 1'b0;
         r_mosi_s1 <= 1'b0;
         r_mosi_s2 <= 1'b0;
      end else begin
         r_ncs_s1  <= nCS;
         r_ncs_s2  <= r_ncs_s1;
         r_ncs_h   <= r_ncs_s2;
         r_sclk_s1 <= SCLK;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_h  <= r_sclk_s2;
         r_mosi_s1 <= MOSI;
         r_mosi_s2 <= r_mosi_s1;
      end
   end

   // State register, plus a short post-reset priming count. The synchronizers
   // reset to nCS = 1, so ARM must wait until the real pin level has flushed
   // through before trusting "nCS high". Otherwise a frame that was in progress
   // at reset release would be accepted.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_state <= ST_ARM;
         r_prime <= 2'd0;
      end else begin
         r_state <= w_next_state;
         if (r_state == ST_ARM && r_prime != 2'd2)
            r_prime <= r_prime + 2'd1;
      end
   end

   // Next-state and datapath strobes. When nCS rises, that edge takes priority
   // over an SCLK rise detected in the same cycle.
   // NOTE: every signal gets a default before the case, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_start      = 1'b0;
      w_shift      = 1'b0;
      w_commit     = 1'b0;
      w_discard    = 1'b0;
      case (r_state)
         ST_ARM: begin
            if (r_prime == 2'd2 && r_ncs_s2)
               w_next_state = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_ncs_fall) begin
               w_next_state = ST_RECV;
               w_start      = 1'b1;
            end
         end
         ST_RECV: begin
            if (w_ncs_rise) begin
               w_next_state = ST_IDLE;
               if (r_count == 4'd8)
                  w_commit = 1'b1;
               else
                  w_discard = 1'b1;
            end else if (w_sclk_rise) begin
               w_shift = 1'b1;
            end
         end
         default: w_next_state = ST_ARM;
      endcase
   end

   // Shift register and bit counter. The counter saturates at 9, so 9 means
   // "more than 8 bits". Outputs are registered here as well.
   always_ff @(posedge clk_i) begin
      if (rst) begin
         r_shift   <= 8'h00;
         r_count   <= 4'd0;
         value     <= RESET_VALUE;
         valid     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         valid     <= w_commit;
         frame_err <= w_discard;
         if (w_commit)
            value <= r_shift;
         if (w_start) begin
            r_shift <= 8'h00;
            r_count <= 4'd0;
         end else if (w_shift) begin
            r_shift <= {r_shift[6:0], r_mosi_s2};
            if (r_count != 4'd9)
               r_count <= r_count + 4'd1;
         end
      end
   end

endmodule

// File: tb/tb_dpot_spi_rx.sv
// Directed bench for dpot_spi_rx. SCLK runs at clk_i/4, and MOSI changes
// while SCLK is low. Inputs are driven and outputs sampled on the falling
// edge of clk_i.
module tb_dpot_spi_rx;

   logic       clk_i = 1'b0;
   logic       rst   = 1'b1;
   logic       nCS   = 1'b1;
   logic       SCLK  = 1'b0;
   logic       MOSI  = 1'b0;
   logic [7:0] value, value0;
   logic       valid, valid0, frame_err, frame_err0, busy, busy0;

   int total = 0;
   int bad   = 0;
   int n_valid = 0, n_err = 0, n_both = 0;
   int v0, e0, lat;

   always #5 clk_i = ~clk_i;

   dpot_spi_rx dut (
      .clk_i(clk_i), .rst(rst), .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI),
      .value(value), .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   dpot_spi_rx #(.RESET_VALUE(8'h00)) dut0 (
      .clk_i(clk_i), .rst(rst), .nCS(nCS), .SCLK(SCLK), .MOSI(MOSI),
      .value(value0), .valid(valid0), .frame_err(frame_err0), .busy(busy0)
   );

   // Count cycles in which each pulse is high. A two-cycle pulse shows up as two.
   always @(negedge clk_i) begin
      if (valid)             n_valid++;
      if (frame_err)         n_err++;
      if (valid && frame_err) n_both++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic sclk_bit(input logic b);
      MOSI = b;
      cycles(2);
      SCLK = 1'b1;
      cycles(2);
      SCLK = 1'b0;
   endtask

   // One frame, MSB-first, using the low nbits of data. With coincide set, nCS
   // rises together with an extra SCLK rising edge.
   task automatic send(input logic [15:0] data, input int nbits, input int gap, input bit coincide);
      nCS = 1'b0;
      cycles(4);
      for (int i = nbits - 1; i >= 0; i--)
         sclk_bit(data[i]);
      cycles(2);
      if (coincide) begin
         SCLK = 1'b1;
         nCS  = 1'b1;
         cycles(2);
         SCLK = 1'b0;
      end else begin
         nCS = 1'b1;
      end
      cycles(gap);
   endtask

   initial begin
      // Reset with nCS high.
      cycles(3);
      rst = 1'b0;
      cycles(4);
      check("reset_value",      value,     32'h80);
      check("reset_value_p00",  value0,    32'h00);
      check("reset_busy",       busy,      32'd0);
      check("reset_valid",      valid,     32'd0);
      check("reset_frame_err",  frame_err, 32'd0);

      // Frame 8'hA5, with the latency measured from the nCS rise to the valid pulse.
      v0 = n_valid; e0 = n_err;
      send(16'h00A5, 8, 0, 1'b0);
      lat = 0;
      while (!valid && lat < 10) begin
         @(negedge clk_i);
         lat++;
      end
      check("a5_latency",   lat,          32'd3);
      check("a5_value",     value,        32'hA5);
      cycles(1);
      check("a5_busy_low",  busy,         32'd0);
      cycles(6);
      check("a5_valid_cnt", n_valid - v0, 32'd1);
      check("a5_err_cnt",   n_err - e0,   32'd0);

      // Short and long frames are discarded.
      v0 = n_valid; e0 = n_err;
      send(16'h007F, 7, 8, 1'b0);
      check("short_err_cnt", n_err - e0, 32'd1);
      check("short_value",   value,      32'hA5);
      send(16'h01FF, 9, 8, 1'b0);
      check("long_err_cnt",  n_err - e0,   32'd2);
      check("long_value",    value,        32'hA5);
      check("bad_valid_cnt", n_valid - v0, 32'd0);

      // An SCLK rise coincident with the nCS rise is not shifted, so 8 bits stay valid.
      v0 = n_valid; e0 = n_err;
      send(16'h005A, 8, 8, 1'b1);
      check("coinc_value",     value,        32'h5A);
      check("coinc_valid_cnt", n_valid - v0, 32'd1);
      check("coinc_err_cnt",   n_err - e0,   32'd0);

      // Release reset while nCS is low mid-frame; that frame must be ignored.
      nCS = 1'b0;
      rst = 1'b1;
      cycles(3);
      rst = 1'b0;
      v0 = n_valid; e0 = n_err;
      for (int i = 0; i < 4; i++) sclk_bit(1'b1);
      cycles(2);
      nCS = 1'b1;
      cycles(8);
      check("midrst_valid_cnt", n_valid - v0, 32'd0);
      check("midrst_err_cnt",   n_err - e0,   32'd0);
      check("midrst_value",     value,        32'h80);
      send(16'h003C, 8, 8, 1'b0);
      check("after_midrst_value", value,        32'h3C);
      check("after_midrst_valid", n_valid - v0, 32'd1);

      // Assert rst during bit 5 of a frame.
      v0 = n_valid; e0 = n_err;
      nCS = 1'b0;
      cycles(4);
      for (int i = 0; i < 4; i++) sclk_bit(1'b0);
      MOSI = 1'b1;
      cycles(2);
      SCLK = 1'b1;
      cycles(1);
      rst = 1'b1;
      cycles(1);
      check("rst_bit5_value", value, 32'h80);
      check("rst_bit5_busy",  busy,  32'd0);
      SCLK = 1'b0;
      nCS  = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(6);
      check("rst_bit5_valid_cnt", n_valid - v0, 32'd0);
      check("rst_bit5_err_cnt",   n_err - e0,   32'd0);

      // Ten back-to-back frames with 2-cycle nCS gaps.
      v0 = n_valid; e0 = n_err;
      for (int k = 0; k < 10; k++)
         send(16'(k), 8, 2, 1'b0);
      cycles(8);
      check("b2b_valid_cnt", n_valid - v0, 32'd10);
      check("b2b_err_cnt",   n_err - e0,   32'd0);
      check("b2b_value",     value,        32'h09);

      // Transmitter-style updates 8'hFF, then 8'h01.
      v0 = n_valid; e0 = n_err;
      send(16'h00FF, 8, 8, 1'b0);
      check("tx_ff_value", value, 32'hFF);
      send(16'h0001, 8, 8, 1'b0);
      check("tx_01_value",   value,        32'h01);
      check("tx_valid_cnt",  n_valid - v0, 32'd2);
      check("tx_err_cnt",    n_err - e0,   32'd0);

      check("never_both", n_both, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dpot_spi_rx.md
# dpot_spi_rx

Receive-side SPI peripheral for the Pmod DPOT link: a behavioural-grade, synthesizable model of the potentiometer's serial input. It oversamples nCS/SCLK/MOSI with a system clock, shifts in 8-bit frames MSB-first on SCLK rising edges, and commits the wiper code only when nCS returns high after exactly 8 bits. It sits opposite the DPOT transmitter in loopback benches and on a second board acting as a DPOT stand-in.

## Interface
- RESET_VALUE, 8'h80, wiper code after reset (midscale)
- clk_i  input  1  system clock; must be ≥ 4× SCLK frequency
- rst  input  1  synchronous, active-high reset
- nCS  input  1  SPI chip select, active low, asynchronous to clk_i
- SCLK  input  1  SPI clock, idle low, asynchronous to clk_i
- MOSI  input  1  SPI data, changes on SCLK falling edge
- value  output  8  committed wiper code
- valid  output  1  one-cycle pulse: value just updated
- frame_err  output  1  one-cycle pulse: frame discarded (bit count ≠ 8)
- busy  output  1  high while a frame is being received (state RECV)

## Operation
- Synchronizers: nCS, SCLK, MOSI each pass through 2 flops, then one history flop; edges from stage2 vs history. Sync/history flops reset to 1 for nCS, 0 for SCLK and MOSI.
- FSM states: ARM, IDLE, RECV.
  - ARM (reset state): wait until synchronized nCS = 1, then → IDLE. No edges acted on. Prevents accepting a frame already in progress at reset release.
  - IDLE: on nCS falling edge → RECV; clear shift register, bit counter (4 bits), overflow flag.
  - RECV: on SCLK rising edge, shift_reg ← {shift_reg[6:0], MOSI_sync}; counter increments, saturating at 9 (≥9 means overflow). On nCS rising edge → IDLE and evaluate: count = 8 → value ← shift_reg, valid pulse; otherwise (0–7 or ≥9) → frame_err pulse, value unchanged.
- SCLK edges while in IDLE or ARM are ignored.
- Simultaneous SCLK rise and nCS rise in one cycle: nCS rise wins, SCLK edge not shifted.
- SCLK falling edges have no effect.
- valid and frame_err never high together; each high for exactly one clk_i cycle.
- Reset values: value = RESET_VALUE, valid = 0, frame_err = 0, busy = 0, state = ARM.
- Reset mid-frame: frame discarded, no valid/frame_err; next frame accepted only after nCS seen high.

## Timing
- Pin-to-detect latency: edge on pin is detected 2–3 clk_i cycles later (synchronizer uncertainty); MOSI shares the same depth, so sample alignment with SCLK is preserved.
- MOSI must be stable ≥ 2 clk_i cycles before and after SCLK rising edge; guaranteed when clk_i ≥ 4× SCLK and MOSI changes on falling edge.
- value and valid update on the same clk_i edge, one cycle after the cycle where nCS rise is detected (combinational edge → registered outputs).
- busy rises the cycle after nCS fall detection, falls with valid/frame_err.
- Back-to-back frames: nCS high time ≥ 2 clk_i cycles required for the rise to be seen; shorter pulses are undefined.
- Throughput: one frame per nCS cycle; no backpressure, value simply overwritten.

## Test plan
- Reset with nCS high, send 8'hA5 MSB-first, SCLK = clk_i/4 -> value = 8'hA5, one valid pulse ~3 clk_i after nCS rise, frame_err stays 0.
- Immediately after reset (no frames) -> value = 8'h80, busy = 0, valid = 0; repeat with RESET_VALUE = 8'h00 -> value = 8'h00.
- Frame of 7 bits then nCS high -> frame_err pulse, value unchanged from 8'hA5; frame of 9 bits -> frame_err, value unchanged.
- Release reset while nCS low mid-frame, clock 4 more bits, raise nCS -> no valid, no frame_err; following 8'h3C frame -> value = 8'h3C.
- Assert rst during bit 5 of a frame -> value = 8'h80 next cycle, no pulses; ten back-to-back frames 8'h00..8'h09 with 2-cycle nCS gaps -> ten valid pulses, final value = 8'h09.
- Connect to DPOT transmitter driven by clkDiv4 from clk_i, issue updates 8'hFF then 8'h01 -> value follows each, valid count = 2.
